pipelined_add_sub: RTL and testbench
====================================

# pipelined_add_sub

Pipelined 32-bit two's-complement add/subtract unit with a valid/ready handshake on both sides. It splits the carry chain into STAGES equal slices, with one slice resolved per pipeline stage, so a new operation can be accepted every cycle. It reports carry-out, signed overflow and zero flags. It is the subtract-capable, clocked counterpart of the ALU's combinational carry-lookahead adder and sits between the ALU operand registers and the writeback/flag logic.

## Interface
- WIDTH, 32: operand and result width in bits; must be divisible by STAGES.
- STAGES, 4: number of pipeline stages, equal to the number of carry-chain slices; slice width is WIDTH/STAGES.

- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operation presented on a/b/sub.
- in_ready  output  1  unit can accept an operation this cycle.
- a  input  WIDTH  first operand (signed two's complement).
- b  input  WIDTH  second operand.
- sub  input  1  0: a+b, 1: a-b.
- out_valid  output  1  result/flags valid.
- out_ready  input  1  consumer accepts the result this cycle.
- result  output  WIDTH  a+b or a-b, modulo 2^WIDTH.
- cout  output  1  carry out of the MSB (for subtract, 1 = no borrow).
- overflow  output  1  signed overflow.
- zero  output  1  result == 0.

## Operation
- Effective operand: b' = sub ? ~b : b. Carry-in = sub.
- Stage k (0..STAGES-1) computes slice k of a + b' using the carry registered by stage k-1; stage 0 uses the carry-in.
- Unresolved upper slices of a/b' and the finished lower sum slices travel with the operation in skew registers.
- Each stage holds a valid bit. A global advance signal, adv = !out_valid || out_ready, moves all stages one step when high; when low, every stage holds.
- in_ready = adv. An operation is accepted when in_valid && in_ready. When in_valid is low during an advance, a bubble (valid=0) enters stage 0.
- Final stage outputs:
  - result: concatenated slices.
  - cout: carry out of the top slice.
  - overflow: (a[MSB] == b'[MSB]) && (result[MSB] != a[MSB]).
  - zero: (result == 0).
- Outputs are registered and hold stable while out_valid && !out_ready.
- Operations leave in acceptance order. None is dropped or duplicated.

## Timing
- Reset: all stage valid bits = 0, out_valid = 0, result = 0, cout = 0, overflow = 0, zero = 0. in_ready = 1 in the cycle after reset deasserts.
- Latency: an operation accepted at edge N appears with out_valid = 1 after edge N+STAGES, assuming no stalls.
- Throughput: one operation per cycle while out_ready = 1.
- Stall: out_valid && !out_ready forces in_ready = 0 in the same cycle (combinational). The pipeline freezes, including bubbles.
- Simultaneous output handshake and new accept: both take effect on the same edge, so there is no bubble insertion penalty.
- rst asserted mid-operation: on the next edge, all in-flight operations are discarded and the outputs take their reset values. Inputs sampled in that cycle are ignored.
- Wrap-around: the result is always taken modulo 2^WIDTH. The flags report the wrap and never saturate.
- Flags and data are produced together in the same cycle as out_valid and belong to the same operation.

## Test plan
- Positive overflow: a = 0x7FFFFFFF, b = 1, sub = 0 -> after 4 cycles: result 0x80000000, overflow 1, cout 0, zero 0.
- Negative overflow via subtract: a = 0x80000000, b = 1, sub = 1 -> result 0x7FFFFFFF, overflow 1, cout 1.
- Mixed-sign and zero cases, back-to-back one per cycle:
  - 100 - 90 -> result 10, cout 1.
  - -100 + -90 -> result 0xFFFFFF42 (-190), cout 1, overflow 0.
  - 10 - 10 -> result 0, zero 1, cout 1.
  - Results appear on consecutive cycles 4..6 after the first accept.
- Backpressure: stream 3456 - 8347 (expect 0xFFFFECE5 = -4891), 3456 + 8347 (11803), 0 + 0 (zero 1), holding out_ready = 0 from the first out_valid for 5 cycles:
  - in_ready = 0 during the stall.
  - result stays 0xFFFFECE5.
  - After release, the three results arrive in order on consecutive cycles.
- Bubbles: in_valid pulsed every third cycle with out_ready = 1 -> out_valid pulses exactly every third cycle, each 4 cycles after its accept, with correct results.
- Reset mid-flight: accept 2 operations, assert rst for 1 cycle at cycle 2:
  - out_valid stays 0, all flags 0.
  - The first operation accepted after reset completes alone with latency 4.

Source files
------------

// File: rtl/pipelined_add_sub_if.sv
// rtl/pipelined_add_sub_if.sv - operand/result handshake bundle for the pipelined adder
interface pipelined_add_sub_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, result, cout, overflow, zero
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, result, cout, overflow, zero
    );
endinterface

// File: rtl/pipelined_add_sub.sv
// rtl/pipelined_add_sub.sv - carry-sliced pipelined add/subtract with carry, overflow and zero flags
module pipelined_add_sub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic              clk,
    input  logic              rst,
    pipelined_add_sub_if.slave bus
);
    localparam int SW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    // Stage j register holds an operation with j low slices already summed:
    // w_q carries the finished sum slices below and the untouched a slices above.
    logic [STAGES-1:0] v_q, v_d;
    logic [STAGES-1:0] c_q, c_d;
    logic [WIDTH-1:0]  w_q  [STAGES];
    logic [WIDTH-1:0]  w_d  [STAGES];
    logic [WIDTH-1:0]  bp_q [STAGES];
    logic [WIDTH-1:0]  bp_d [STAGES];

    logic [SW:0]       slice_sum [STAGES];
    logic [WIDTH-1:0]  merged    [STAGES];

    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              cout_q, cout_d;
    logic              overflow_q, overflow_d;
    logic              zero_q, zero_d;

    logic              adv;

    assign adv = !out_valid_q || bus.out_ready;

    always_comb begin
        for (int j = 0; j < STAGES; j++) begin
            slice_sum[j] = {1'b0, w_q[j][j*SW +: SW]}
                         + {1'b0, bp_q[j][j*SW +: SW]}
                         + {{SW{1'b0}}, c_q[j]};
            merged[j] = w_q[j];
            merged[j][j*SW +: SW] = slice_sum[j][SW-1:0];
        end
    end

    always_comb begin
        v_d     = '0;
        c_d     = '0;
        w_d     = w_q;
        bp_d    = bp_q;

        v_d[0]  = bus.in_valid;
        c_d[0]  = bus.sub;
        w_d[0]  = bus.a;
        bp_d[0] = bus.sub ? ~bus.b : bus.b;

        for (int j = 1; j < STAGES; j++) begin
            v_d[j]  = v_q[j-1];
            c_d[j]  = slice_sum[j-1][SW];
            w_d[j]  = merged[j-1];
            bp_d[j] = bp_q[j-1];
        end

        // Bubbles leave all-zero outputs so flags never show stale data.
        out_valid_d = v_q[LAST];
        result_d    = v_q[LAST] ? merged[LAST] : '0;
        cout_d      = v_q[LAST] & slice_sum[LAST][SW];
        overflow_d  = v_q[LAST]
                    & (w_q[LAST][WIDTH-1] == bp_q[LAST][WIDTH-1])
                    & (merged[LAST][WIDTH-1] != w_q[LAST][WIDTH-1]);
        zero_d      = v_q[LAST] & (merged[LAST] == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q         <= '0;
            c_q         <= '0;
            for (int j = 0; j < STAGES; j++) begin
                w_q[j]  <= '0;
                bp_q[j] <= '0;
            end
            out_valid_q <= 1'b0;
            result_q    <= '0;
            cout_q      <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
        end else if (adv) begin
            v_q         <= v_d;
            c_q         <= c_d;
            w_q         <= w_d;
            bp_q        <= bp_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            cout_q      <= cout_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
        end
    end

    assign bus.in_ready  = adv;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.cout      = cout_q;
    assign bus.overflow  = overflow_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_pipelined_add_sub.sv
// tb/tb_pipelined_add_sub.sv - randomized and directed bench against an arithmetic reference model
module tb_pipelined_add_sub;
    localparam int WIDTH  = 32;
    localparam int STAGES = 4;
    localparam longint MAXS = 64'sh0000_0000_7FFF_FFFF;
    localparam longint MINS = -64'sh0000_0000_8000_0000;

    typedef struct {
        logic [31:0] res;
        logic        cout;
        logic        ovf;
        logic        zero;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    bit   check_lat = 1'b0;

    pipelined_add_sub_if #(.WIDTH(WIDTH)) bus ();

    pipelined_add_sub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic sub, input int acc);
        exp_t   e;
        longint sa, sb, r;
        logic [32:0] usum;
        sa = $signed(a);
        sb = $signed(b);
        r  = sub ? sa - sb : sa + sb;
        usum = {1'b0, a} + {1'b0, b};
        e.res  = r[31:0];
        e.ovf  = (r > MAXS) || (r < MINS);
        e.cout = sub ? (a >= b) : usum[32];
        e.zero = (e.res == 32'd0);
        e.acc  = acc;
        return e;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom % 6)
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (rst) begin
            exp_q.delete();
        end else begin
            check("in_ready", bus.in_ready, !bus.out_valid || bus.out_ready);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("out_unexpected", bus.out_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("result",   bus.result,   e.res);
                    check("cout",     bus.cout,     e.cout);
                    check("overflow", bus.overflow, e.ovf);
                    check("zero",     bus.zero,     e.zero);
                    if (check_lat) check("latency", cyc - e.acc, STAGES + 1);
                end
            end
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(model(bus.a, bus.b, bus.sub, cyc));
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub);
        bus.a = a;
        bus.b = b;
        bus.sub = sub;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() > 0; i++) tick();
        check("drain_empty", exp_q.size(), 0);
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.sub = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_out_valid", bus.out_valid, 0);
        check("rst_result",    bus.result,    0);
        check("rst_cout",      bus.cout,      0);
        check("rst_overflow",  bus.overflow,  0);
        check("rst_zero",      bus.zero,      0);
        check("rst_in_ready",  bus.in_ready,  1);

        // Signed overflow in both directions
        check_lat = 1'b1;
        send(32'h7FFF_FFFF, 32'h1, 1'b0);
        drain();
        send(32'h8000_0000, 32'h1, 1'b1);
        drain();

        // Back-to-back mixed-sign and zero results
        send(32'd100, 32'd90, 1'b1);
        send(-32'sd100, -32'sd90, 1'b0);
        send(32'd10, 32'd10, 1'b1);
        drain();

        // Backpressure holds the first result on the output
        check_lat = 1'b0;
        bus.out_ready = 1'b0;
        send(32'd3456, 32'd8347, 1'b1);
        send(32'd3456, 32'd8347, 1'b0);
        send(32'd0, 32'd0, 1'b0);
        for (int i = 0; i < 20 && !bus.out_valid; i++) tick();
        check("bp_out_valid", bus.out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            check("bp_in_ready", bus.in_ready, 0);
            check("bp_hold",     bus.result,   32'hFFFF_ECE5);
            tick();
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("bp_release_valid", bus.out_valid, 1);
            tick();
        end
        drain();

        // Bubbles between isolated operations
        check_lat = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(pick(), pick(), 1'($urandom));
            tick();
            tick();
        end
        drain();

        // Reset while two operations are in flight
        send(pick(), pick(), 1'($urandom));
        send(pick(), pick(), 1'($urandom));
        bus.a = pick();
        bus.b = pick();
        bus.in_valid = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("flush_out_valid", bus.out_valid, 0);
            check("flush_result",    bus.result,    0);
            check("flush_cout",      bus.cout,      0);
            check("flush_overflow",  bus.overflow,  0);
            check("flush_zero",      bus.zero,      0);
            tick();
        end
        send(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        drain();

        // Random traffic with random backpressure
        check_lat = 1'b0;
        for (int i = 0; i < 400; i++) begin
            bus.in_valid  = 1'($urandom);
            bus.a         = pick();
            bus.b         = pick();
            bus.sub       = 1'($urandom);
            bus.out_ready = ($urandom % 4) != 0;
            tick();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
